// File: rtl/burst_bus_memory.sv
// Multiplexed-bus burst memory: address phase then LEN+1 data beats on one tri-state bus.
// First beat LATENCY+1 cycles after the REQ edge; reads add one bus-turnaround cycle.
// No backpressure: REQ is taken only in IDLE; REQ while busy is dropped, not queued.
module burst_bus_memory #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int LATENCY   = 1,
  parameter int MAX_BURST = 4
) (
  input  logic                         CLK,
  input  logic                         RST,
  inout  wire  [DATA_W-1:0]            BUS,
  input  logic                         REQ,
  input  logic                         RD,
  input  logic [$clog2(MAX_BURST)-1:0] LEN,
  output logic                         ACK,
  output logic                         BUSY,
  output logic                         DONE,
  output logic                         ERR
);

  localparam int LEN_W = $clog2(MAX_BURST);
  // Depth compared one bit wider so DEPTH == 2**ADDR_W never rejects.
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);
  localparam logic [3:0]        WLOAD_C = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, XFER, TURN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rd_q, rd_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [3:0]          wcnt_q, wcnt_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                req_bad;

  logic [DATA_W-1:0]   mem [0:DEPTH-1];

  assign req_bad = {1'b0, BUS[ADDR_W-1:0]} >= DEPTH_C;

  // Next-state and counter logic; flag pulses default low every cycle.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    wcnt_d  = wcnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (REQ) begin
          if (req_bad) begin
            err_d = 1'b1;
          end else begin
            addr_d = BUS[ADDR_W-1:0];
            rd_d   = RD;
            cnt_d  = LEN;
            if (LATENCY > 0) begin
              state_d = WAIT;
              wcnt_d  = WLOAD_C;
            end else begin
              state_d = XFER;
            end
          end
        end
      end
      WAIT: begin
        if (wcnt_q == 4'd0) state_d = XFER;
        else                wcnt_d  = wcnt_q - 4'd1;
      end
      XFER: begin
        addr_d = (addr_q == LAST_C) ? '0 : addr_q + ADDR_W'(1);
        cnt_d  = cnt_q - LEN_W'(1);
        if (cnt_q == '0) begin
          done_d  = 1'b1;
          state_d = rd_q ? TURN : IDLE;
        end
      end
      TURN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control registers; synchronous reset aborts any transfer in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      cnt_q   <= '0;
      wcnt_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Write beats commit at the edge; a reset edge suppresses the beat in flight.
  always_ff @(posedge CLK) begin
    if (!RST && state_q == XFER && !rd_q) mem[addr_q] <= BUS;
  end

  assign BUS  = (state_q == XFER && rd_q) ? mem[addr_q] : {DATA_W{1'bz}};
  assign ACK  = (state_q == XFER);
  assign BUSY = (state_q != IDLE);
  assign DONE = done_q;
  assign ERR  = err_q;

endmodule

// File: doc/burst_bus_memory.md
# burst_bus_memory

Parametrised multiplexed-bus memory: the successor to the single-beat `Memory` on the shared 8-bit address/data bus (`uniBus`). It adds configurable data/address width, depth, access latency and multi-beat bursts with address auto-increment and wrap. It sits between `Core` and the shared bus, and exchanges address and data phases with the core over one tri-state bus plus a request/acknowledge handshake.

## Interface
- `DATA_W`, 8: bus and word width.
- `ADDR_W`, 8: address width; must satisfy ADDR_W <= DATA_W, with the address carried in BUS[ADDR_W-1:0].
- `DEPTH`, 256: number of words; must satisfy DEPTH <= 2**ADDR_W.
- `LATENCY`, 1: wait cycles between the address phase and the first data beat; range 0..15.
- `MAX_BURST`, 4: maximum beats per request; power of 2, >= 2.

- `CLK`  in  1: sole clock, rising edge.
- `RST`  in  1: synchronous, active-high reset.
- `BUS`  inout  DATA_W: multiplexed bus carrying the address phase and the data phases.
- `REQ`  in  1: request strobe, sampled only in IDLE.
- `RD`  in  1: access direction, 1 = read, 0 = write; sampled with REQ.
- `LEN`  in  $clog2(MAX_BURST): number of beats minus 1; sampled with REQ.
- `ACK`  out  1: beat valid. On a read, BUS carries data. On a write, BUS is captured at the next edge.
- `BUSY`  out  1: high whenever state != IDLE.
- `DONE`  out  1: one-cycle pulse marking the cycle after the last beat.
- `ERR`  out  1: one-cycle pulse for a rejected request.

## Operation
- Storage: `mem[0:DEPTH-1]`, DATA_W bits per word. Reset does not clear it. The bench preloads it hierarchically.
- States: IDLE, WAIT, XFER, TURN.
- IDLE, edge with REQ=1:
  - If the address (BUS[ADDR_W-1:0]) >= DEPTH: pulse ERR next cycle, stay in IDLE, no access.
  - Otherwise latch addr, RD and LEN into `rd_q` and `cnt`.
  - Next state is WAIT with `wcnt`=LATENCY-1 if LATENCY>0, otherwise XFER.
- WAIT: `wcnt` decrements each cycle; when `wcnt`=0, go to XFER.
- XFER: one beat per cycle, ACK=1.
  - Read: BUS driven with mem[addr].
  - Write: mem[addr] <= BUS at the edge.
  - Each edge: addr <= (addr==DEPTH-1) ? 0 : addr+1, and `cnt` decrements.
  - Edge with `cnt`=0: a read goes to TURN, a write goes to IDLE. DONE=1 in the following cycle.
- TURN: one cycle with the bus released and BUSY=1, giving the core bus turnaround; then IDLE.
- The memory drives BUS only in XFER with `rd_q`=1; at all other times BUS is Z.
- REQ while BUSY=1 is ignored, with no ERR and no queuing.
- After a write, REQ in the DONE cycle (state IDLE) is accepted.
- Address arithmetic is modulo DEPTH, not 2**ADDR_W. Bursts wrap DEPTH-1 -> 0.

## Timing
- Reset values, valid after the first rising edge with RST=1:
  - state=IDLE; ACK=0, BUSY=0, DONE=0, ERR=0; BUS=Z; `cnt`, `wcnt` and addr = 0.
- RST overrides everything, including a REQ sampled in the same cycle.
- Reset mid-operation aborts immediately. Write beats already clocked stay committed; no further beats occur and no DONE is issued.
- REQ sampled at edge E0 means the first ACK occurs in cycle E0+1+LATENCY.
- Number of ACK cycles = LEN+1, contiguous, with no gaps.
- Cycles from REQ edge to return to IDLE:
  - Read: LATENCY+LEN+3.
  - Write: LATENCY+LEN+2.
- ERR is asserted in cycle E0+1 only. BUSY stays 0 throughout.
- ACK, BUSY, DONE and ERR are registered state decodes, free of glitches relative to CLK. Read data on BUS is combinational from registered addr.

## Test plan
- **Read burst (defaults):** preload mem[0..3]=10,11,12,13; REQ with RD=1, BUS=00, LEN=3. Required: ACK high for 4 cycles starting 2 cycles after the REQ edge, with BUS=10,11,12,13; then TURN with BUS=Z; DONE pulses one cycle; BUSY falls after TURN.
- **Write burst with readback:** REQ with RD=0, BUS=FD, LEN=2; core drives AA,AB,AC during ACK cycles. Required: mem[FD..FF]=AA,AB,AC. A subsequent read of FD with LEN=2 returns AA,AB,AC.
- **Wrap and range check, DEPTH=200 instance:**
  - Write at C7 with LEN=1, data 55,66. Required: mem[C7]=55, mem[00]=66.
  - REQ with BUS=C8. Required: ERR pulse of 1 cycle, BUSY=0, memory unchanged.
- **Latency and back-to-back, LATENCY=0 instance:**
  - REQ write with LEN=0. Required: ACK in the cycle right after the REQ edge.
  - Second REQ in the DONE cycle. Required: accepted, and its ACK follows one cycle later.
  - REQ asserted while BUSY=1. Required: ignored.
- **Reset mid-burst:**
  - Read with LEN=3; assert RST during the second ACK. Required: after the edge, BUS=Z, ACK=0, BUSY=0, no DONE.
  - Write with LEN=3; assert RST during the third ACK. Required: the first two words are written and the rest are untouched.
